// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: ALU operation codes,
// instruction opcodes, FSM state/step codes, opcode classes and the
// bundle of datapath control strobes.
package control_pkg;

  // ALU operation codes driven on alu_op
  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_SHR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_ROR = 4'd6,
    ALU_ROL = 4'd7,
    ALU_MUL = 4'd8,
    ALU_DIV = 4'd9,
    ALU_NEG = 4'd10,
    ALU_NOT = 4'd11
  } alu_op_e;

  // Instruction opcodes (ir[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // FSM states; the encoding doubles as the step debug code
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd14,
    ST_FAULT = 4'd15
  } state_e;

  // Execution flavour of a decoded opcode
  typedef enum logic [2:0] {
    CLS_LD   = 3'd0,
    CLS_LDI  = 3'd1,
    CLS_ST   = 3'd2,
    CLS_ALU  = 3'd3,
    CLS_NOP  = 3'd4,
    CLS_HALT = 3'd5,
    CLS_ILL  = 3'd6
  } op_class_e;

  // All datapath control strobes for one step
  typedef struct packed {
    logic    pc_out;
    logic    z_low_out;
    logic    mdr_out;
    logic    c_out;
    logic    ba_out;
    logic    r_out;
    logic    pc_in;
    logic    mar_in;
    logic    mdr_in;
    logic    ir_in;
    logic    y_in;
    logic    z_in;
    logic    r_in;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    inc_pc;
    logic    read;
    logic    write;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic op_class_e op_class(input logic [4:0] opc);
    op_class_e cls;
    case (opc)
      OP_LD:   cls = CLS_LD;
      OP_LDI:  cls = CLS_LDI;
      OP_ST:   cls = CLS_ST;
      OP_ADD:  cls = CLS_ALU;
      OP_SUB:  cls = CLS_ALU;
      OP_AND:  cls = CLS_ALU;
      OP_OR:   cls = CLS_ALU;
      OP_NOP:  cls = CLS_NOP;
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_ILL;
    endcase
    return cls;
  endfunction

  function automatic alu_op_e alu_of(input logic [4:0] opc);
    alu_op_e op;
    case (opc)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer (master) and the datapath/instruction
// side (slave): run/ir/mem_ready inputs and every control strobe and status.
interface control_sequencer_if #(
  parameter int STEP_W = 4
);
  logic              run;
  logic [31:0]       ir;
  logic              mem_ready;
  logic              pc_out, z_low_out, mdr_out, c_out, ba_out, r_out;
  logic              pc_in, mar_in, mdr_in, ir_in, y_in, z_in, r_in;
  logic              gra, grb, grc;
  logic              inc_pc, read, write;
  logic [3:0]        alu_op;
  logic [STEP_W-1:0] step;
  logic              done, halted, fault, illegal;

  modport master (
    input  run, ir, mem_ready,
    output pc_out, z_low_out, mdr_out, c_out, ba_out, r_out,
           pc_in, mar_in, mdr_in, ir_in, y_in, z_in, r_in,
           gra, grb, grc, inc_pc, read, write, alu_op, step,
           done, halted, fault, illegal
  );

  modport slave (
    output run, ir, mem_ready,
    input  pc_out, z_low_out, mdr_out, c_out, ba_out, r_out,
           pc_in, mar_in, mdr_in, ir_in, y_in, z_in, r_in,
           gra, grb, grc, inc_pc, read, write, alu_op, step,
           done, halted, fault, illegal
  );
endinterface

// File: rtl/control_sequencer_mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for mem_ready and flags a
// timeout once WAIT_MAX unanswered cycles have elapsed.
module mem_wait_timer #(
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic timeout_o
);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on wait entry, saturate at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == LIMIT);
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch / decode / execute FSM producing the
// datapath strobes. All outputs are registered from the next state, so they
// track the state register and never follow inputs combinationally.
// Optional macro CONTROL_SEQUENCER_RETIRE_COUNT_EN adds the 32-bit
// `retired` instruction counter output.
module control_sequencer
  import control_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int STEP_W   = 4,
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
  output logic [31:0] retired,
`endif
  control_sequencer_if.master bus
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic                done_q, halted_q, fault_q, illegal_q;
  logic                retire_s, illegal_set_s, first_t1_s;
  logic                wait_s, clear_s, count_s, timeout_s;
  state_e              next_fetch_s;
  op_class_e           cls_s, cls_d;
  logic                unused_ir_s;

  assign opcode_d    = (state_q == ST_T2) ? bus.ir[31 -: OPCODE_W] : opcode_q;
  assign cls_s       = op_class(5'(opcode_q));
  assign cls_d       = op_class(5'(opcode_d));
  assign next_fetch_s = bus.run ? ST_T0 : ST_IDLE;
  assign unused_ir_s = ^bus.ir[31-OPCODE_W:0];

  // Wait steps, and the steps that always lead into one
  assign wait_s  = (state_q == ST_T1) ||
                   ((state_q == ST_T6) && (cls_s == CLS_LD)) ||
                   ((state_q == ST_T7) && (cls_s == CLS_ST));
  assign clear_s = (state_q == ST_T0) ||
                   ((state_q == ST_T5) && (cls_s == CLS_LD)) ||
                   ((state_q == ST_T6) && (cls_s == CLS_ST));
  assign count_s = wait_s && !bus.mem_ready && !timeout_s;

  mem_wait_timer #(
    .WAIT_W   (WAIT_W),
    .WAIT_MAX (WAIT_MAX)
  ) u_wait (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (clear_s),
    .count_i   (count_s),
    .timeout_o (timeout_s)
  );

  // Next-state sequencing, retire and illegal-opcode detection
  always_comb begin
    state_d       = state_q;
    retire_s      = 1'b0;
    illegal_set_s = 1'b0;
    case (state_q)
      ST_IDLE: state_d = next_fetch_s;
      ST_T0:   state_d = ST_T1;
      ST_T1: begin
        if (bus.mem_ready)  state_d = ST_T2;
        else if (timeout_s) state_d = ST_FAULT;
        else                state_d = ST_T1;
      end
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (cls_s)
          CLS_LD, CLS_LDI, CLS_ST, CLS_ALU: state_d = ST_T4;
          CLS_HALT: state_d = ST_HALT;
          CLS_NOP: begin
            state_d  = next_fetch_s;
            retire_s = 1'b1;
          end
          default: begin
            state_d       = next_fetch_s;
            retire_s      = 1'b1;
            illegal_set_s = 1'b1;
          end
        endcase
      end
      ST_T4:   state_d = ST_T5;
      ST_T5: begin
        if ((cls_s == CLS_LD) || (cls_s == CLS_ST)) begin
          state_d = ST_T6;
        end else begin
          state_d  = next_fetch_s;
          retire_s = 1'b1;
        end
      end
      ST_T6: begin
        if (cls_s == CLS_ST)    state_d = ST_T7;
        else if (bus.mem_ready) state_d = ST_T7;
        else if (timeout_s)     state_d = ST_FAULT;
        else                    state_d = ST_T6;
      end
      ST_T7: begin
        if ((cls_s == CLS_LD) || bus.mem_ready) begin
          state_d  = next_fetch_s;
          retire_s = 1'b1;
        end else if (timeout_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_T7;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  assign first_t1_s = (state_d == ST_T1) && (state_q != ST_T1);

  // Strobe decode for the state being entered (registered below)
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_T0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
        ctrl_d.z_in   = 1'b1;
        ctrl_d.alu_op = ALU_ADD;
      end
      ST_T1: begin
        ctrl_d.read      = 1'b1;
        ctrl_d.mdr_in    = 1'b1;
        ctrl_d.z_low_out = first_t1_s;
        ctrl_d.pc_in     = first_t1_s;
      end
      ST_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      ST_T3: begin
        if (cls_d == CLS_ALU) begin
          ctrl_d.grb  = 1'b1;
          ctrl_d.r_out = 1'b1;
          ctrl_d.y_in = 1'b1;
        end else if ((cls_d == CLS_LD) || (cls_d == CLS_LDI) || (cls_d == CLS_ST)) begin
          ctrl_d.grb    = 1'b1;
          ctrl_d.ba_out = 1'b1;
          ctrl_d.y_in   = 1'b1;
        end else begin
          ctrl_d = '0;
        end
      end
      ST_T4: begin
        ctrl_d.z_in = 1'b1;
        if (cls_d == CLS_ALU) begin
          ctrl_d.grc    = 1'b1;
          ctrl_d.r_out  = 1'b1;
          ctrl_d.alu_op = alu_of(5'(opcode_d));
        end else begin
          ctrl_d.c_out  = 1'b1;
          ctrl_d.alu_op = ALU_ADD;
        end
      end
      ST_T5: begin
        ctrl_d.z_low_out = 1'b1;
        if ((cls_d == CLS_LD) || (cls_d == CLS_ST)) begin
          ctrl_d.mar_in = 1'b1;
        end else begin
          ctrl_d.gra  = 1'b1;
          ctrl_d.r_in = 1'b1;
        end
      end
      ST_T6: begin
        ctrl_d.mdr_in = 1'b1;
        if (cls_d == CLS_ST) begin
          ctrl_d.gra   = 1'b1;
          ctrl_d.r_out = 1'b1;
        end else begin
          ctrl_d.read = 1'b1;
        end
      end
      ST_T7: begin
        if (cls_d == CLS_ST) begin
          ctrl_d.write = 1'b1;
        end else begin
          ctrl_d.mdr_out = 1'b1;
          ctrl_d.gra     = 1'b1;
          ctrl_d.r_in    = 1'b1;
        end
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, latched opcode, strobes and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      ctrl_q    <= '0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      ctrl_q    <= ctrl_d;
      done_q    <= retire_s;
      halted_q  <= (state_d == ST_HALT);
      fault_q   <= (state_d == ST_FAULT);
      illegal_q <= illegal_q | illegal_set_s;
    end
  end

`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
  logic [31:0] retired_q;

  // Retired-instruction counter, moves together with the done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 32'd0;
    end else if (retire_s) begin
      retired_q <= retired_q + 32'd1;
    end else begin
      retired_q <= retired_q;
    end
  end

  assign retired = retired_q;
`endif

  assign bus.pc_out    = ctrl_q.pc_out;
  assign bus.z_low_out = ctrl_q.z_low_out;
  assign bus.mdr_out   = ctrl_q.mdr_out;
  assign bus.c_out     = ctrl_q.c_out;
  assign bus.ba_out    = ctrl_q.ba_out;
  assign bus.r_out     = ctrl_q.r_out;
  assign bus.pc_in     = ctrl_q.pc_in;
  assign bus.mar_in    = ctrl_q.mar_in;
  assign bus.mdr_in    = ctrl_q.mdr_in;
  assign bus.ir_in     = ctrl_q.ir_in;
  assign bus.y_in      = ctrl_q.y_in;
  assign bus.z_in      = ctrl_q.z_in;
  assign bus.r_in      = ctrl_q.r_in;
  assign bus.gra       = ctrl_q.gra;
  assign bus.grb       = ctrl_q.grb;
  assign bus.grc       = ctrl_q.grc;
  assign bus.inc_pc    = ctrl_q.inc_pc;
  assign bus.read      = ctrl_q.read;
  assign bus.write     = ctrl_q.write;
  assign bus.alu_op    = ctrl_q.alu_op;
  assign bus.step      = STEP_W'(state_q);
  assign bus.done      = done_q;
  assign bus.halted    = halted_q;
  assign bus.fault     = fault_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle stimulus and expected
// outputs are queued by a small instruction model, then replayed and compared.
`timescale 1ns/1ps
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_sequencer_if #(.STEP_W(4)) bus ();

`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  control_sequencer dut (
    .clk     (clk),
    .reset   (reset),
`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
    .retired (retired),
`endif
    .bus     (bus)
  );

  // strobe bit masks, same order as obs_sb
  localparam logic [18:0] M_PC_OUT = 19'h40000, M_Z_LOW  = 19'h20000, M_MDR_OUT = 19'h10000;
  localparam logic [18:0] M_C_OUT  = 19'h08000, M_BA_OUT = 19'h04000, M_R_OUT   = 19'h02000;
  localparam logic [18:0] M_PC_IN  = 19'h01000, M_MAR_IN = 19'h00800, M_MDR_IN  = 19'h00400;
  localparam logic [18:0] M_IR_IN  = 19'h00200, M_Y_IN   = 19'h00100, M_Z_IN    = 19'h00080;
  localparam logic [18:0] M_R_IN   = 19'h00040, M_GRA    = 19'h00020, M_GRB     = 19'h00010;
  localparam logic [18:0] M_GRC    = 19'h00008, M_INC_PC = 19'h00004, M_READ    = 19'h00002;
  localparam logic [18:0] M_WRITE  = 19'h00001;

  logic [18:0] obs_sb;
  assign obs_sb = {bus.pc_out, bus.z_low_out, bus.mdr_out, bus.c_out, bus.ba_out, bus.r_out,
                   bus.pc_in, bus.mar_in, bus.mdr_in, bus.ir_in, bus.y_in, bus.z_in, bus.r_in,
                   bus.gra, bus.grb, bus.grc, bus.inc_pc, bus.read, bus.write};

  typedef struct {
    logic        run;
    logic [31:0] ir;
    logic        mr;
    logic [3:0]  st;
    logic [18:0] sb;
    logic [3:0]  alu;
    logic        done;
    logic [2:0]  flg;   // {halted, fault, illegal}
    logic [31:0] ret;
  } rec_t;

  rec_t        sbq[$];
  logic        pend_done;
  logic [2:0]  m_flg;
  logic [31:0] m_ret;
  int          n_checks;
  int          n_fail;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic run, input logic [31:0] irv, input logic mr,
                      input logic [3:0] st, input logic [18:0] sb, input logic [3:0] alu);
    rec_t r;
    r.run = run; r.ir = irv; r.mr = mr; r.st = st; r.sb = sb; r.alu = alu;
    r.done = pend_done;
    if (pend_done) m_ret = m_ret + 32'd1;
    pend_done = 1'b0;
    r.flg = m_flg;
    r.ret = m_ret;
    sbq.push_back(r);
  endtask

  // IDLE cycle with run raised, launching a fetch
  task automatic model_start();
    push(1'b1, $urandom, rb(), 4'd0, 19'h0, 4'd0);
  endtask

  // Queue one complete instruction; t1w / mw are not-ready cycles before mem_ready
  task automatic model_instr(input logic [31:0] irv, input int t1w, input int mw, input logic keep);
    logic [4:0] opc;
    opc = irv[31:27];
    push(keep, irv, rb(), 4'd1, M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN, 4'd2);
    for (int i = 0; i <= t1w; i++)
      push(keep, irv, (i == t1w), 4'd2, M_READ | M_MDR_IN | ((i == 0) ? (M_Z_LOW | M_PC_IN) : 19'h0), 4'd0);
    push(keep, irv, rb(), 4'd3, M_MDR_OUT | M_IR_IN, 4'd0);
    case (opc)
      5'b00000, 5'b00001, 5'b00010: begin
        push(keep, $urandom, rb(), 4'd4, M_GRB | M_BA_OUT | M_Y_IN, 4'd0);
        push(keep, $urandom, rb(), 4'd5, M_C_OUT | M_Z_IN, 4'd2);
        if (opc == 5'b00001) begin
          push(keep, $urandom, rb(), 4'd6, M_Z_LOW | M_GRA | M_R_IN, 4'd0);
        end else begin
          push(keep, $urandom, rb(), 4'd6, M_Z_LOW | M_MAR_IN, 4'd0);
          if (opc == 5'b00000) begin
            for (int i = 0; i <= mw; i++)
              push(keep, $urandom, (i == mw), 4'd7, M_READ | M_MDR_IN, 4'd0);
            push(keep, $urandom, rb(), 4'd8, M_MDR_OUT | M_GRA | M_R_IN, 4'd0);
          end else begin
            push(keep, $urandom, rb(), 4'd7, M_GRA | M_R_OUT | M_MDR_IN, 4'd0);
            for (int i = 0; i <= mw; i++)
              push(keep, $urandom, (i == mw), 4'd8, M_WRITE, 4'd0);
          end
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push(keep, $urandom, rb(), 4'd4, M_GRB | M_R_OUT | M_Y_IN, 4'd0);
        push(keep, $urandom, rb(), 4'd5, M_GRC | M_R_OUT | M_Z_IN,
             (opc == 5'b00011) ? 4'd2 : (opc == 5'b00100) ? 4'd3 : (opc == 5'b00101) ? 4'd0 : 4'd1);
        push(keep, $urandom, rb(), 4'd6, M_Z_LOW | M_GRA | M_R_IN, 4'd0);
      end
      5'b11011: begin
        push(keep, $urandom, rb(), 4'd4, 19'h0, 4'd0);
        m_flg[2] = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, $urandom, rb(), 4'd14, 19'h0, 4'd0);
        return;
      end
      5'b11010: push(keep, $urandom, rb(), 4'd4, 19'h0, 4'd0);
      default: begin
        push(keep, $urandom, rb(), 4'd4, 19'h0, 4'd0);
        m_flg[0] = 1'b1;
      end
    endcase
    pend_done = 1'b1;
    if (!keep) push(1'b0, $urandom, rb(), 4'd0, 19'h0, 4'd0);
  endtask

  // Replay the queue: compare current outputs, then drive this cycle's inputs
  task automatic run_sb(input string tag);
    rec_t r;
    int   cyc;
    cyc = 0;
    while (sbq.size() > 0) begin
      r = sbq.pop_front();
      n_checks++;
      if ({bus.step, obs_sb, bus.alu_op, bus.done, bus.halted, bus.fault, bus.illegal} !==
          {r.st, r.sb, r.alu, r.done, r.flg}) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got step=%0d sb=%h alu=%0d done=%b hfi=%b, want step=%0d sb=%h alu=%0d done=%b hfi=%b",
                 tag, cyc, bus.step, obs_sb, bus.alu_op, bus.done,
                 {bus.halted, bus.fault, bus.illegal}, r.st, r.sb, r.alu, r.done, r.flg);
      end
`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
      n_checks++;
      if (retired !== r.ret) begin
        n_fail++;
        $display("FAIL %s_retired cyc%0d: got %0d want %0d", tag, cyc, retired, r.ret);
      end
`endif
      bus.run = r.run; bus.ir = r.ir; bus.mem_ready = r.mr;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({bus.step, obs_sb, bus.alu_op, bus.done, bus.halted, bus.fault, bus.illegal} !== 30'h0) begin
      n_fail++;
      $display("FAIL %s: got step=%0d sb=%h alu=%0d done=%b hfi=%b, want all 0", tag,
               bus.step, obs_sb, bus.alu_op, bus.done, {bus.halted, bus.fault, bus.illegal});
    end
`ifdef CONTROL_SEQUENCER_RETIRE_COUNT_EN
    n_checks++;
    if (retired !== 32'd0) begin
      n_fail++;
      $display("FAIL %s_retired: got %0d want 0", tag, retired);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.run = 1'b1; bus.ir = 32'h0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    bus.run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_release");
  endtask

  // Asynchronous reset in the middle of a cycle, outputs checked before any edge
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    bus.run = 1'b0;
    #1;
    reset = 1'b0;
    m_flg = 3'b000; m_ret = 32'd0; pend_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ld();
    model_start();
    model_instr(32'h0080_0064, 0, 0, 1'b0);
    run_sb("ld");
  endtask

  task automatic test_st();
    model_start();
    model_instr(32'h1000_1234, 0, 3, 1'b0);
    run_sb("st");
  endtask

  task automatic test_back_to_back();
    model_start();
    model_instr(32'h1800_0001, 0, 0, 1'b1);  // add
    model_instr(32'h2000_0002, 1, 0, 1'b1);  // sub
    model_instr(32'h2800_0003, 0, 0, 1'b1);  // and
    model_instr(32'h3000_0004, 2, 0, 1'b1);  // or
    model_instr(32'h0800_0005, 0, 0, 1'b0);  // ldi
    run_sb("alu_b2b");
  endtask

  task automatic test_wait_limit();
    model_start();
    model_instr(32'h0000_0010, 15, 15, 1'b1);  // ld, ready on the last allowed cycle
    model_instr(32'h1000_0020, 0, 15, 1'b0);   // st, same at T7
    run_sb("wait_limit");
  endtask

  task automatic test_illegal();
    model_start();
    model_instr(32'hF800_0000, 0, 0, 1'b1);  // undefined 11111
    model_instr(32'hD000_0000, 0, 0, 1'b1);  // nop
    model_instr(32'h0000_0040, 0, 1, 1'b0);  // ld
    run_sb("illegal");
  endtask

  task automatic test_timeout();
    logic [31:0] irv;
    irv = 32'h0000_0000;
    model_start();
    push(1'b1, irv, rb(), 4'd1, M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN, 4'd2);
    for (int i = 0; i < 16; i++)
      push(1'b1, irv, 1'b0, 4'd2, M_READ | M_MDR_IN | ((i == 0) ? (M_Z_LOW | M_PC_IN) : 19'h0), 4'd0);
    m_flg[1] = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, irv, 1'b1, 4'd15, 19'h0, 4'd0);
    run_sb("timeout");
    reset_pulse("timeout_reset");
  endtask

  task automatic test_halt();
    model_start();
    model_instr(32'hD800_0000, 0, 0, 1'b1);
    run_sb("halt");
    reset_pulse("halt_reset");
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    pend_done = 1'b0; m_flg = 3'b000; m_ret = 32'd0;
    test_reset();
    test_ld();
    test_st();
    test_back_to_back();
    test_wait_limit();
    test_illegal();
    test_timeout();
    test_halt();
    test_ld();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
